// File: rtl/defines_package.sv
// Shared definitions for the frame-buffer fill and scanout paths.
//   Color          : pixel word stored in the frame buffer
//   FbAddrSize     : frame-buffer address width (from `FRAME_BUFFER_ADDR_SIZE)
//   ScreenWidth/Height : default frame geometry (from `SCREEN_WIDTH / `SCREEN_HEIGHT)
//   scan_state_e   : scanout controller states
//   scan_entry_t   : one return-buffer entry {pixel, end-of-line, end-of-frame}

`ifndef FRAME_BUFFER_ADDR_SIZE
`define FRAME_BUFFER_ADDR_SIZE 19
`endif

`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif

`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

package defines_package;

    typedef logic [15:0] Color;

    localparam int unsigned FbAddrSize   = `FRAME_BUFFER_ADDR_SIZE;
    localparam int unsigned ScreenWidth  = `SCREEN_WIDTH;
    localparam int unsigned ScreenHeight = `SCREEN_HEIGHT;

    typedef enum logic [1:0] {
        ScanIdle,
        ScanIssue,
        ScanDrain,
        ScanDone
    } scan_state_e;

    typedef struct packed {
        Color data;
        logic eol;
        logic eof;
    } scan_entry_t;

endpackage

// File: rtl/fb_scanout_fifo.sv
// scan_fifo: synchronous FIFO buffering frame-buffer return data for the scanout path.
//   clk, n_rst     : clock, asynchronous active-low reset (empties the FIFO)
//   push_i         : write push_data_i (caller guarantees not full unless popping)
//   push_data_i    : {pixel, eol, eof} entry
//   pop_i          : remove the head entry (ignored when empty)
//   head_o         : current head entry (meaningful only when !empty_o)
//   count_o        : number of stored entries
//   empty_o/full_o : occupancy flags

module scan_fifo
    import defines_package::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         push_i,
    input  scan_entry_t                  push_data_i,
    input  logic                         pop_i,
    output scan_entry_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    scan_entry_t     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntFull);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    no_overflow_a : assert property (@(posedge clk) disable iff (!n_rst)
        !(push_i && full_o && !pop_i))
        else $error("scan_fifo: push into full FIFO");

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: reads a whole frame out of the frame buffer in raster order and streams it
// to the video output stage.
//   clk, n_rst   : clock, asynchronous active-low reset
//   start        : one-cycle pulse, starts a frame when idle
//   fb_addr      : frame-buffer read address (row*WIDTH+col, running counter)
//   fb_read_en   : read strobe, one pixel per high cycle
//   fb_rdata     : read data, valid RD_LATENCY cycles after its strobe
//   pix_data     : output pixel; pix_valid/pix_ready handshake
//   pix_eol/eof  : last pixel of row / of frame
//   busy         : frame in progress
//   done         : one-cycle pulse after the last pixel is accepted

module fb_scanout
    import defines_package::*;
#(
    parameter int unsigned WIDTH      = ScreenWidth,
    parameter int unsigned HEIGHT     = ScreenHeight,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    output logic [FbAddrSize-1:0] fb_addr,
    output logic                  fb_read_en,
    input  Color                  fb_rdata,
    output Color                  pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_eol,
    output logic                  pix_eof,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);

    if (RD_LATENCY < 1) begin : g_bad_latency
        $error("fb_scanout: RD_LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("fb_scanout: FIFO_DEPTH must be at least RD_LATENCY+1");
    end
    if (64'(WIDTH) * 64'(HEIGHT) > (64'd1 << FbAddrSize)) begin : g_bad_addr
        $error("fb_scanout: WIDTH*HEIGHT does not fit the frame-buffer address");
    end

    scan_state_e           state_q, state_d;
    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [FbAddrSize-1:0] addr_q, addr_d;

    // Strobe flags and their row/frame tags travel together through the latency pipe.
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [RD_LATENCY-1:0] eol_pipe_q, eol_pipe_d;
    logic [RD_LATENCY-1:0] eof_pipe_q, eof_pipe_d;

    int unsigned     inflight;
    logic            credit_ok, rd_en;
    logic            issue_eol, issue_eof;
    logic            fifo_push, fifo_pop, fifo_empty, fifo_full, last_pop;
    logic [CntW-1:0] fifo_count;
    scan_entry_t     push_entry, head_entry;

    assign issue_eol = (col_q == ColLast);
    assign issue_eof = issue_eol && (row_q == RowLast);

    always_comb begin
        inflight = 0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + {31'b0, rd_pipe_q[i]};
        end
    end

    // Reserve a FIFO slot for every read still in flight so a push never overflows.
    assign credit_ok = ({{(32-CntW){1'b0}}, fifo_count} + inflight) < FIFO_DEPTH;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ScanIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ScanIdle:  if (start) state_d = ScanIssue;
            ScanIssue: if (rd_en && issue_eof) state_d = ScanDrain;
            ScanDrain: if (last_pop) state_d = ScanDone;
            ScanDone:  state_d = ScanIdle;
            default:   state_d = ScanIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ScanIssue: begin
                rd_en = credit_ok;
                busy  = 1'b1;
            end
            ScanDrain: busy = 1'b1;
            ScanDone:  done = 1'b1;
            default:   ;
        endcase
    end

    assign fb_read_en = rd_en;
    assign fb_addr    = addr_q;

    // Raster counters and the latency pipe.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (state_q == ScanIdle && start) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (rd_en) begin
            addr_d = addr_q + 1'b1;
            if (issue_eol) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        rd_pipe_d[0]  = rd_en;
        eol_pipe_d[0] = rd_en && issue_eol;
        eof_pipe_d[0] = rd_en && issue_eof;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            rd_pipe_d[i]  = rd_pipe_q[i-1];
            eol_pipe_d[i] = eol_pipe_q[i-1];
            eof_pipe_d[i] = eof_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            rd_pipe_q  <= '0;
            eol_pipe_q <= '0;
            eof_pipe_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            rd_pipe_q  <= rd_pipe_d;
            eol_pipe_q <= eol_pipe_d;
            eof_pipe_q <= eof_pipe_d;
        end
    end

    // Return path: the oldest pipe stage lines up with fb_rdata.
    assign fifo_push  = rd_pipe_q[RD_LATENCY-1];
    assign push_entry = '{data: fb_rdata,
                          eol:  eol_pipe_q[RD_LATENCY-1],
                          eof:  eof_pipe_q[RD_LATENCY-1]};
    assign fifo_pop   = pix_valid && pix_ready;

    // The eof entry leaving as the sole occupant with nothing in flight ends the frame.
    assign last_pop = fifo_pop && head_entry.eof && (inflight == 0) &&
                      (fifo_count == CntW'(1));

    scan_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .n_rst       (n_rst),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Head fields are gated so idle outputs read as zero.
    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? head_entry.data : '0;
    assign pix_eol   = pix_valid && head_entry.eol;
    assign pix_eof   = pix_valid && head_entry.eof;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: 4x3 frame with RD_LATENCY=2 plus a 1x2 edge instance.
// The memory model returns the read address as the pixel value.

module tb_fb_scanout;
    import defines_package::*;

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic                  start, pix_ready;
    logic [FbAddrSize-1:0] fb_addr;
    logic                  fb_read_en;
    Color                  fb_rdata, pix_data;
    logic                  pix_valid, pix_eol, pix_eof, busy, done;

    logic                  start_e, pix_ready_e;
    logic [FbAddrSize-1:0] fb_addr_e;
    logic                  fb_read_en_e;
    Color                  fb_rdata_e, pix_data_e;
    logic                  pix_valid_e, pix_eol_e, pix_eof_e, busy_e, done_e;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_scanout #(
        .WIDTH      (4),
        .HEIGHT     (3),
        .RD_LATENCY (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .fb_addr    (fb_addr),
        .fb_read_en (fb_read_en),
        .fb_rdata   (fb_rdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .busy       (busy),
        .done       (done)
    );

    fb_scanout #(
        .WIDTH      (1),
        .HEIGHT     (2),
        .RD_LATENCY (1),
        .FIFO_DEPTH (2)
    ) dut_e (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start_e),
        .fb_addr    (fb_addr_e),
        .fb_read_en (fb_read_en_e),
        .fb_rdata   (fb_rdata_e),
        .pix_data   (pix_data_e),
        .pix_valid  (pix_valid_e),
        .pix_ready  (pix_ready_e),
        .pix_eol    (pix_eol_e),
        .pix_eof    (pix_eof_e),
        .busy       (busy_e),
        .done       (done_e)
    );

    // Memory models: data = address, exactly RD_LATENCY cycles after the strobe.
    Color mem0_q, mem1_q, meme_q;
    int   strobe_cnt   = 0;
    int   strobe_cnt_e = 0;

    always_ff @(posedge clk) begin
        mem0_q <= fb_read_en ? Color'(fb_addr) : 16'hBAD0;
        mem1_q <= mem0_q;
        meme_q <= fb_read_en_e ? Color'(fb_addr_e) : 16'hBAD0;
        if (fb_read_en)   strobe_cnt   <= strobe_cnt + 1;
        if (fb_read_en_e) strobe_cnt_e <= strobe_cnt_e + 1;
    end

    assign fb_rdata   = mem1_q;
    assign fb_rdata_e = meme_q;

    // Observations gathered by run_frame for the calling test to judge.
    Color acc_data[$];
    logic acc_eol[$];
    logic acc_eof[$];
    int   first_valid_k, done_k, done_cnt, stall_viol, max_outst;
    int   frame_strobes, stall_strobes;
    logic busy_k1, busy_end, stall_head_valid;
    Color stall_head_data;

    // Runs one frame on the main DUT starting at a negedge. k counts cycles after start.
    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ready low for k <= stall_len.
    task automatic run_frame(input int mode, input int stall_len, input bit spam);
        int   s0, outst;
        logic prev_stall;
        Color prev_data;
        acc_data.delete();
        acc_eol.delete();
        acc_eof.delete();
        first_valid_k = -1; done_k = -1; done_cnt = 0; stall_viol = 0; max_outst = 0;
        stall_strobes = -1; stall_head_valid = 1'b0; stall_head_data = '0; busy_k1 = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        s0 = strobe_cnt;
        start = 1'b1;
        pix_ready = (mode == 0);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
                default: pix_ready = (k > stall_len);
            endcase
            start = spam && ((k == 6) || (done === 1'b1));
            if (k == 1) busy_k1 = busy;
            if (k == stall_len) begin
                stall_head_valid = pix_valid;
                stall_head_data  = pix_data;
            end
            if (k == stall_len + 1) stall_strobes = strobe_cnt - s0;
            if (pix_valid && first_valid_k < 0) first_valid_k = k;
            if (prev_stall && (!pix_valid || pix_data !== prev_data)) stall_viol++;
            outst = strobe_cnt - s0 - acc_data.size();
            if (outst > max_outst) max_outst = outst;
            if (pix_valid && pix_ready) begin
                acc_data.push_back(pix_data);
                acc_eol.push_back(pix_eol);
                acc_eof.push_back(pix_eof);
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 4) break;
        end
        start         = 1'b0;
        busy_end      = busy;
        frame_strobes = strobe_cnt - s0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; pix_ready = 1'b0; start_e = 1'b0; pix_ready_e = 1'b0;
        #1;
        checks++;
        if ({fb_read_en, fb_addr, pix_valid, pix_data, pix_eol, pix_eof, busy, done} !== '0)
        begin
            failures++;
            $display("FAIL reset_outputs: got rd=%0b addr=%0d v=%0b d=%0d eol=%0b eof=%0b busy=%0b done=%0b expected all 0",
                     fb_read_en, fb_addr, pix_valid, pix_data, pix_eol, pix_eof, busy, done);
        end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pix_valid, busy, done, fb_read_en} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got v/busy/done/rd=%b expected 0000",
                     {pix_valid, busy, done, fb_read_en});
        end
    endtask

    task automatic test_full_frame();
        run_frame(0, 0, 1'b0);
        checks++;
        if (acc_data.size() != 12) begin
            failures++;
            $display("FAIL full_count: got %0d expected 12", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 12; i++) begin
            checks++;
            if ({acc_data[i], acc_eol[i], acc_eof[i]} !==
                {Color'(i), (i % 4) == 3, i == 11}) begin
                failures++;
                $display("FAIL full_pixel[%0d]: got d=%0d eol=%0b eof=%0b expected d=%0d eol=%0b eof=%0b",
                         i, acc_data[i], acc_eol[i], acc_eof[i], i, (i % 4) == 3, i == 11);
            end
        end
        checks++;
        if (first_valid_k != 4) begin
            failures++;
            $display("FAIL first_valid_latency: got %0d expected 4", first_valid_k);
        end
        checks++;
        if (done_k != 16 || done_cnt != 1) begin
            failures++;
            $display("FAIL done_pulse: got cycle=%0d count=%0d expected cycle=16 count=1",
                     done_k, done_cnt);
        end
        checks++;
        if (busy_k1 !== 1'b1 || busy_end !== 1'b0) begin
            failures++;
            $display("FAIL busy: got first=%0b end=%0b expected 1 then 0", busy_k1, busy_end);
        end
        checks++;
        if (frame_strobes != 12) begin
            failures++;
            $display("FAIL full_strobes: got %0d expected 12", frame_strobes);
        end
    endtask

    task automatic test_backpressure();
        run_frame(1, 0, 1'b0);
        checks++;
        if (acc_data.size() != 12) begin
            failures++;
            $display("FAIL bp_count: got %0d expected 12", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 12; i++) begin
            checks++;
            if ({acc_data[i], acc_eol[i], acc_eof[i]} !==
                {Color'(i), (i % 4) == 3, i == 11}) begin
                failures++;
                $display("FAIL bp_pixel[%0d]: got d=%0d eol=%0b eof=%0b expected d=%0d eol=%0b eof=%0b",
                         i, acc_data[i], acc_eol[i], acc_eof[i], i, (i % 4) == 3, i == 11);
            end
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d unstable stalled cycles expected 0", stall_viol);
        end
        checks++;
        if (max_outst > 4) begin
            failures++;
            $display("FAIL bp_outstanding: got %0d expected at most 4", max_outst);
        end
        checks++;
        if (done_cnt != 1 || frame_strobes != 12) begin
            failures++;
            $display("FAIL bp_done: got done=%0d strobes=%0d expected 1 and 12",
                     done_cnt, frame_strobes);
        end
    endtask

    task automatic test_stall_release();
        run_frame(2, 20, 1'b0);
        checks++;
        if (stall_strobes != 4) begin
            failures++;
            $display("FAIL stall_strobes: got %0d expected 4", stall_strobes);
        end
        checks++;
        if (stall_head_valid !== 1'b1 || stall_head_data !== 16'd0) begin
            failures++;
            $display("FAIL stall_head: got v=%0b d=%0d expected v=1 d=0",
                     stall_head_valid, stall_head_data);
        end
        checks++;
        if (acc_data.size() != 12 || acc_data[acc_data.size()-1] !== 16'd11 ||
            acc_eof[acc_data.size()-1] !== 1'b1) begin
            failures++;
            $display("FAIL stall_frame: got n=%0d expected 12 ending in pixel 11 with eof",
                     acc_data.size());
        end
        checks++;
        if (done_cnt != 1 || max_outst > 4) begin
            failures++;
            $display("FAIL stall_done: got done=%0d outstanding=%0d expected 1 and <=4",
                     done_cnt, max_outst);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic hit;
        int   bad;
        hit = 1'b0;
        pix_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (pix_valid && pix_data == 16'd6) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_reach_pixel6: got timeout expected pixel 6 within 40 cycles");
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({fb_read_en, fb_addr, pix_valid, pix_data, pix_eol, pix_eof, busy, done} !== '0)
        begin
            failures++;
            $display("FAIL mid_reset_outputs: got rd=%0b addr=%0d v=%0b d=%0d busy=%0b done=%0b expected all 0",
                     fb_read_en, fb_addr, pix_valid, pix_data, busy, done);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if ({fb_read_en, pix_valid, busy, done} !== 4'b0) bad++;
        end
        n_rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if ({fb_read_en, pix_valid, busy, done} !== 4'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_quiet: got %0d active cycles expected 0", bad);
        end
        run_frame(0, 0, 1'b0);
        checks++;
        if (acc_data.size() != 12) begin
            failures++;
            $display("FAIL restart_count: got %0d expected 12", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 12; i++) begin
            checks++;
            if (acc_data[i] !== Color'(i)) begin
                failures++;
                $display("FAIL restart_pixel[%0d]: got %0d expected %0d", i, acc_data[i], i);
            end
        end
    endtask

    task automatic test_start_ignored();
        run_frame(0, 0, 1'b1);
        checks++;
        if (frame_strobes != 12 || acc_data.size() != 12) begin
            failures++;
            $display("FAIL spam_single_frame: got strobes=%0d pixels=%0d expected 12 and 12",
                     frame_strobes, acc_data.size());
        end
        checks++;
        if (done_cnt != 1 || busy_end !== 1'b0) begin
            failures++;
            $display("FAIL spam_idle: got done=%0d busy=%0b expected 1 and 0",
                     done_cnt, busy_end);
        end
    endtask

    task automatic test_edge_config();
        Color d[$];
        logic e[$];
        logic f[$];
        int   first_k, dk, s0;
        first_k = -1; dk = -1;
        s0 = strobe_cnt_e;
        pix_ready_e = 1'b1;
        start_e = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_e = 1'b0;
            if (pix_valid_e && first_k < 0) first_k = k;
            if (pix_valid_e && pix_ready_e) begin
                d.push_back(pix_data_e);
                e.push_back(pix_eol_e);
                f.push_back(pix_eof_e);
            end
            if (done_e && dk < 0) dk = k;
        end
        checks++;
        if (d.size() != 2 || strobe_cnt_e - s0 != 2) begin
            failures++;
            $display("FAIL edge_count: got pixels=%0d strobes=%0d expected 2 and 2",
                     d.size(), strobe_cnt_e - s0);
        end
        for (int i = 0; i < d.size() && i < 2; i++) begin
            checks++;
            if ({d[i], e[i], f[i]} !== {Color'(i), 1'b1, i == 1}) begin
                failures++;
                $display("FAIL edge_pixel[%0d]: got d=%0d eol=%0b eof=%0b expected d=%0d eol=1 eof=%0b",
                         i, d[i], e[i], f[i], i, i == 1);
            end
        end
        checks++;
        if (first_k != 3 || dk != 5) begin
            failures++;
            $display("FAIL edge_timing: got first=%0d done=%0d expected 3 and 5", first_k, dk);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_stall_release();
        test_reset_mid_frame();
        test_start_ignored();
        test_edge_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Reader-side counterpart of the colour fill path. Fill writes pixels into the frame buffer; this block reads a complete frame back out, in raster order.
- On a start pulse it walks row 0..HEIGHT-1 and column 0..WIDTH-1, issuing one frame-buffer read per pixel.
- It absorbs the fixed memory read latency and streams Color pixels to the display/output stage over a valid/ready handshake, with line and frame markers.
- It sits between the frame buffer's read port and the video output stage.

Parameters:
- WIDTH, 640, pixels per row.
- HEIGHT, 480, rows per frame.
- RD_LATENCY, 2, cycles from fb_read_en high to fb_rdata valid (fixed, at least 1).
- FIFO_DEPTH, 4, return-data buffer entries (at least RD_LATENCY+1).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- fb_addr  out  `FRAME_BUFFER_ADDR_SIZE  read address = row*WIDTH+col.
- fb_read_en  out  1  read strobe, one pixel per high cycle.
- fb_rdata  in  Color  read data, valid exactly RD_LATENCY cycles after its strobe.
- pix_data  out  Color  output pixel.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accepts when pix_valid and pix_ready are both high.
- pix_eol  out  1  qualifies pix_data as the last pixel of its row.
- pix_eof  out  1  qualifies pix_data as the last pixel of the frame.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: state IDLE, all counters 0, FIFO empty.
  - Outputs: fb_read_en=0, fb_addr=0, pix_valid=0, pix_data=0, pix_eol=0, pix_eof=0, busy=0, done=0.
  - In-flight read returns are discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE when start=1. Row, column and address counters are cleared to 0. start is ignored in every other state.
  - ISSUE: fb_read_en=1 whenever credit is available.
    - Credit = fifo_count + inflight < FIFO_DEPTH, where inflight is the number of strobes issued in the last RD_LATENCY cycles.
    - fb_addr is a running counter incremented by 1 per issued read; no multiplier.
    - The column wraps at WIDTH-1 to 0 and the row then increments.
    - After the read for (HEIGHT-1, WIDTH-1) is issued -> DRAIN.
  - DRAIN: no reads issued. When the FIFO is empty, inflight=0 and the final pixel has been accepted -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE.
- Return path:
  - A RD_LATENCY-deep shift register of strobe flags marks valid returns.
  - A flagged return pushes fb_rdata into the FIFO together with its eol/eof tags, computed from the issuing column/row and carried through the latency pipe.
- Output:
  - pix_valid = FIFO not empty; pix_data, pix_eol and pix_eof are driven from the FIFO head.
  - A pop happens on pix_valid & pix_ready.
  - With pix_ready held high the stream is gap-free.
  - Latency from start to the first pix_valid is RD_LATENCY+2 cycles: 1 cycle to enter ISSUE, RD_LATENCY cycles of memory, 1 cycle of FIFO write.
- Boundaries:
  - Simultaneous push and pop: count is unchanged.
  - Credit rule guarantees no push into a full FIFO. Overflow is a design error; assert it in simulation.
  - pix_ready low for any duration: issue stalls within RD_LATENCY cycles, no data lost, pix_data held stable while pix_valid=1 and not accepted.
  - WIDTH=1 or HEIGHT=1: eol/eof still correct. eol=1 on every pixel when WIDTH=1.
  - Reset mid-frame returns to IDLE immediately; no done pulse.
  - start in the same cycle as DONE is ignored.
- Width rules:
  - Column and row counters are $clog2(WIDTH) and $clog2(HEIGHT) bits (minimum 1).
  - fb_addr is zero-extended to `FRAME_BUFFER_ADDR_SIZE.
  - WIDTH*HEIGHT must fit in the address width; check with an elaboration-time assertion.

Decomposition:
- Shared package (defines_package): Color typedef, `FRAME_BUFFER_ADDR_SIZE, new `SCREEN_WIDTH/`SCREEN_HEIGHT used as parameter defaults, and the scanout state enum typedef.
- One sub-module, scan_fifo: synchronous FIFO of {Color, eol, eof} with push, pop, count, empty and full; parameter DEPTH.

Test Plan:
- Full frame, WIDTH=4, HEIGHT=3, RD_LATENCY=2, pix_ready=1, memory model fb_rdata = address -> 12 pixels 0..11 on consecutive cycles. eol on pixels 3, 7 and 11; eof only on pixel 11. done pulses once, 1 cycle after pixel 11 is accepted. First pix_valid appears 4 cycles after start.
- Backpressure, same configuration, pix_ready toggled 1,0,0,1 repeating -> exactly 12 pixels accepted, in order, none duplicated. pix_data is stable while stalled. fifo_count never exceeds 4 and the overflow assertion never fires.
- pix_ready=0 for 20 cycles after start -> reads stop after 4 strobes, FIFO holds 4 entries, then the frame completes normally once pix_ready=1.
- Reset asserted on pixel 6 -> all outputs at reset values during and after reset, no done pulse. A new start then yields pixels 0..11 from the beginning.
- start pulsed during busy and again in the DONE cycle -> both ignored; exactly one frame is read (12 strobes).
- Edge configuration WIDTH=1, HEIGHT=2, RD_LATENCY=1 -> 2 pixels, both with eol=1, eof only on the second, addresses 0 then 1.
